// File: rtl/input_logic_gen2.sv
// eFPGA tile input logic: a configuration shift chain selects, inverts and optionally registers one tile input bit per lane.
// Optional build macro CFG_PARITY_EN adds per-word even-parity checking on the configuration stream (prog_par/cfg_err).
module input_logic_gen2 #(
    parameter int DATA_W = 32,
    parameter int CFG_W  = 32,
    parameter int N_CB   = 32,
    parameter int N_CBV  = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic [CFG_W-1:0]  prog_i,
    input  logic              prog_shft,
    output logic [CFG_W-1:0]  prog_o,
    input  logic [DATA_W-1:0] data_in,
    input  logic              en,
    output logic [N_CB-1:0]   data_oCB,
    output logic [N_CBV-1:0]  data_oCBV,
    output logic              cfg_ok
`ifdef CFG_PARITY_EN
   ,input  logic              prog_par,
    output logic              cfg_err
`endif
);
    localparam int SEL_W     = $clog2(DATA_W);
    localparam int FLD_W     = SEL_W + 2;
    localparam int N_LANE    = N_CB + N_CBV;
    localparam int USED_W    = N_LANE * FLD_W;
    localparam int CFG_DEPTH = (USED_W + CFG_W - 1) / CFG_W;
    localparam int CHAIN_W   = CFG_DEPTH * CFG_W;
    localparam int CNT_W     = $clog2(CFG_DEPTH + 2);

    logic [CFG_W-1:0]   chain_q [CFG_DEPTH];
    logic [CHAIN_W-1:0] chain_flat_s;
    logic               prog_shft_d_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_ok_q, cfg_ok_d;
    logic               burst_start_s, burst_end_s, load_err_s;
    logic [N_LANE-1:0]  lane_v_s, lane_reg_s, lane_out_s;
    logic [N_LANE-1:0]  lane_r_q, lane_r_d;

    // Configuration chain: word 0 is the oldest word and cascades out on prog_o.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < CFG_DEPTH; i++) chain_q[i] <= '0;
        end else if (prog_shft) begin
            for (int i = 0; i < CFG_DEPTH - 1; i++) chain_q[i] <= chain_q[i+1];
            chain_q[CFG_DEPTH-1] <= prog_i;
        end
    end

    always_comb begin
        chain_flat_s = '0;
        for (int i = 0; i < CFG_DEPTH; i++) chain_flat_s[i*CFG_W +: CFG_W] = chain_q[i];
    end

    generate
        if (CHAIN_W > USED_W) begin : g_pad
            logic unused_pad_s;
            assign unused_pad_s = ^chain_flat_s[CHAIN_W-1:USED_W];
        end
    endgenerate

    assign burst_start_s = prog_shft & ~prog_shft_d_q;
    assign burst_end_s   = ~prog_shft & prog_shft_d_q;

`ifdef CFG_PARITY_EN
    logic cfg_err_q, cfg_err_d, word_err_s;

    assign word_err_s = prog_shft & (^{prog_i, prog_par});

    // Sticky word-parity error, restarted with each new burst.
    always_comb begin
        cfg_err_d = cfg_err_q | word_err_s;
        if (burst_start_s) begin
            cfg_err_d = word_err_s;
        end else begin
            cfg_err_d = cfg_err_q | word_err_s;
        end
    end

    always_ff @(posedge clk) begin
        if (res) cfg_err_q <= 1'b0;
        else     cfg_err_q <= cfg_err_d;
    end

    assign load_err_s = cfg_err_d;
    assign cfg_err    = cfg_err_q;
`else
    assign load_err_s = 1'b0;
`endif

    // Loaded-word check: cfg_ok only when a burst delivered exactly CFG_DEPTH words.
    always_comb begin
        cnt_d    = cnt_q;
        cfg_ok_d = cfg_ok_q;
        if (burst_start_s) begin
            cnt_d    = CNT_W'(1);
            cfg_ok_d = 1'b0;
        end else if (prog_shft) begin
            cnt_d    = (cnt_q == CNT_W'(CFG_DEPTH + 1)) ? cnt_q : cnt_q + CNT_W'(1);
            cfg_ok_d = 1'b0;
        end else if (burst_end_s) begin
            cnt_d    = cnt_q;
            cfg_ok_d = (cnt_q == CNT_W'(CFG_DEPTH)) & ~load_err_s;
        end else begin
            cnt_d    = cnt_q;
            cfg_ok_d = cfg_ok_q;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            prog_shft_d_q <= 1'b0;
            cnt_q         <= '0;
            cfg_ok_q      <= 1'b0;
        end else begin
            prog_shft_d_q <= prog_shft;
            cnt_q         <= cnt_d;
            cfg_ok_q      <= cfg_ok_d;
        end
    end

    // Per-lane select/invert and the combinational-or-registered output choice.
    always_comb begin
        lane_v_s   = '0;
        lane_reg_s = '0;
        lane_r_d   = '0;
        lane_out_s = '0;
        for (int k = 0; k < N_LANE; k++) begin
            logic [FLD_W-1:0] fld;
            logic [SEL_W-1:0] sel;
            logic             bit_v;
            fld = chain_flat_s[k*FLD_W +: FLD_W];
            sel = fld[SEL_W-1:0];
            if (int'(sel) < DATA_W) begin
                bit_v = data_in[sel];
            end else begin
                bit_v = 1'b0;
            end
            lane_v_s[k]   = bit_v ^ fld[SEL_W];
            lane_reg_s[k] = fld[SEL_W+1];
            if (cfg_ok_q) begin
                lane_r_d[k] = en ? lane_v_s[k] : lane_r_q[k];
            end else begin
                lane_r_d[k] = 1'b0;
            end
            if (lane_reg_s[k]) begin
                lane_out_s[k] = lane_r_q[k];
            end else begin
                lane_out_s[k] = lane_v_s[k] & en & cfg_ok_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) lane_r_q <= '0;
        else     lane_r_q <= lane_r_d;
    end

    assign prog_o    = chain_q[0];
    assign cfg_ok    = cfg_ok_q;
    assign data_oCB  = lane_out_s[N_CB-1:0];
    assign data_oCBV = lane_out_s[N_LANE-1:N_CB];
endmodule

// File: tb/tb_input_logic_gen2.sv
// Directed, table-driven bench for input_logic_gen2 at default parameters (9-word chain, 40 lanes of 7 bits).
module tb_input_logic_gen2;
    logic        clk = 1'b0;
    logic        res;
    logic [31:0] prog_i;
    logic        prog_shft;
    logic [31:0] prog_o;
    logic [31:0] data_in;
    logic        en;
    logic [31:0] data_oCB;
    logic [7:0]  data_oCBV;
    logic        cfg_ok;
`ifdef CFG_PARITY_EN
    logic        prog_par;
    logic        cfg_err;
    logic        par_flip;
    assign prog_par = (^prog_i) ^ par_flip;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_logic_gen2 dut (
        .clk       (clk),
        .res       (res),
        .prog_i    (prog_i),
        .prog_shft (prog_shft),
        .prog_o    (prog_o),
        .data_in   (data_in),
        .en        (en),
        .data_oCB  (data_oCB),
        .data_oCBV (data_oCBV),
        .cfg_ok    (cfg_ok)
`ifdef CFG_PARITY_EN
       ,.prog_par  (prog_par),
        .cfg_err   (cfg_err)
`endif
    );

    typedef struct {
        int          phase;
        logic [31:0] din;
        logic        en;
        logic [31:0] cb;
        logic [7:0]  cbv;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_uniform(input int n, input logic [31:0] w);
        for (int i = 0; i < n; i++) begin
            prog_shft = 1'b1;
            prog_i    = w;
            tick();
        end
        prog_shft = 1'b0;
        tick();
    endtask

    initial begin
        logic [287:0] cfg;
        logic [39:0]  exp_l;
        logic [31:0]  pat;
        int           cur;

        res = 1'b1; prog_i = '0; prog_shft = 1'b0; data_in = '0; en = 1'b0;
`ifdef CFG_PARITY_EN
        par_flip = 1'b0;
`endif
        tick(); tick();
        check("rst_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        check("rst_prog_o", prog_o, 32'd0);
        check("rst_cb", data_oCB, 32'd0);
        check("rst_cbv", {24'd0, data_oCBV}, 32'd0);
`ifdef CFG_PARITY_EN
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
`endif
        res = 1'b0;

        // phase 0: all-zero config (sel=0, comb); phase 1: all-ones config (sel=31, inv, reg)
        vecs[0]  = '{0, 32'h00000001, 1'b1, 32'hFFFFFFFF, 8'hFF};
        vecs[1]  = '{0, 32'h00000001, 1'b0, 32'h00000000, 8'h00};
        vecs[2]  = '{0, 32'h00000002, 1'b1, 32'h00000000, 8'h00};
        vecs[3]  = '{0, 32'h80000003, 1'b1, 32'hFFFFFFFF, 8'hFF};
        vecs[4]  = '{1, 32'h80000000, 1'b1, 32'h00000000, 8'h00};
        vecs[5]  = '{1, 32'h00000000, 1'b1, 32'hFFFFFFFF, 8'hFF};
        vecs[6]  = '{1, 32'h80000000, 1'b0, 32'hFFFFFFFF, 8'hFF};
        vecs[7]  = '{1, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 8'hFF};
        vecs[8]  = '{1, 32'hFFFFFFFF, 1'b1, 32'h00000000, 8'h00};
        vecs[9]  = '{1, 32'h00000000, 1'b0, 32'h00000000, 8'h00};
        vecs[10] = '{1, 32'h00000000, 1'b1, 32'hFFFFFFFF, 8'hFF};

        cur = -1;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].phase != cur) begin
                cur = vecs[i].phase;
                load_uniform(9, (cur == 1) ? 32'hFFFFFFFF : 32'h00000000);
                check("load_cfg_ok", {31'd0, cfg_ok}, 32'd1);
            end
            data_in = vecs[i].din;
            en      = vecs[i].en;
            tick();
            check($sformatf("vec%0d_cb", i), data_oCB, vecs[i].cb);
            check($sformatf("vec%0d_cbv", i), {24'd0, data_oCBV}, {24'd0, vecs[i].cbv});
        end

        // Distinct per-lane selects/inverts to exercise the field mapping
        cfg = {288{1'b0}};
        cfg[287:280] = 8'hA5;
        for (int k = 0; k < 40; k++) begin
            cfg[k*7 +: 5] = 5'((k * 7 + 3) % 32);
            cfg[k*7 + 5]  = ((k % 3) == 0);
        end
        for (int i = 0; i < 9; i++) begin
            prog_shft = 1'b1;
            prog_i    = cfg[i*32 +: 32];
            tick();
        end
        prog_shft = 1'b0;
        tick();
        check("mix_cfg_ok", {31'd0, cfg_ok}, 32'd1);
        check("mix_prog_o", prog_o, cfg[31:0]);
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? 32'h1234ABCD : 32'hF0F00F0F;
            data_in = pat;
            for (int k = 0; k < 40; k++) exp_l[k] = pat[(k * 7 + 3) % 32] ^ ((k % 3) == 0);
            #1;
            check($sformatf("mix%0d_cb", p), data_oCB, exp_l[31:0]);
            check($sformatf("mix%0d_cbv", p), {24'd0, data_oCBV}, {24'd0, exp_l[39:32]});
        end

        // Short and long bursts
        load_uniform(9, 32'h0);
        data_in = 32'h1; en = 1'b1;
        #1;
        check("pre_short_cb", data_oCB, 32'hFFFFFFFF);
        prog_shft = 1'b1; prog_i = 32'h0;
        tick();
        check("rise_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        check("rise_cb", data_oCB, 32'd0);
        for (int i = 1; i < 8; i++) tick();
        prog_shft = 1'b0;
        tick();
        check("short_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        check("short_cb", data_oCB, 32'd0);
        check("short_cbv", {24'd0, data_oCBV}, 32'd0);
        load_uniform(10, 32'h0);
        check("long_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        check("long_cb", data_oCB, 32'd0);
        check("long_cbv", {24'd0, data_oCBV}, 32'd0);

        // Cascade through prog_o
        prog_shft = 1'b1; prog_i = 32'h87654321;
        tick();
        prog_i = 32'hFEDCAB98;
        for (int i = 0; i < 8; i++) tick();
        check("casc9_prog_o", prog_o, 32'h87654321);
        tick();
        check("casc10_prog_o", prog_o, 32'hFEDCAB98);
        prog_shft = 1'b0;
        tick();
        check("casc10_cfg_ok", {31'd0, cfg_ok}, 32'd0);

        // Reset mid-burst, then recovery
        load_uniform(9, 32'h0);
        check("run_cb", data_oCB, 32'hFFFFFFFF);
        prog_shft = 1'b1; prog_i = 32'hA5A5A5A5;
        for (int i = 0; i < 9; i++) tick();
        check("preres_prog_o", prog_o, 32'hA5A5A5A5);
        res = 1'b1;
        tick();
        res = 1'b0; prog_shft = 1'b0;
        check("res_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        check("res_prog_o", prog_o, 32'd0);
        check("res_cb", data_oCB, 32'd0);
        check("res_cbv", {24'd0, data_oCBV}, 32'd0);
        tick();
        load_uniform(9, 32'h0);
        check("recov_cfg_ok", {31'd0, cfg_ok}, 32'd1);
        check("recov_cb", data_oCB, 32'hFFFFFFFF);
        check("recov_cbv", {24'd0, data_oCBV}, 32'hFF);

`ifdef CFG_PARITY_EN
        for (int i = 1; i <= 9; i++) begin
            prog_shft = 1'b1;
            prog_i    = 32'h0F0F0001 + 32'(i);
            par_flip  = (i == 5);
            tick();
            if (i == 4) check("par_w4_err", {31'd0, cfg_err}, 32'd0);
            if (i == 5) check("par_w5_err", {31'd0, cfg_err}, 32'd1);
        end
        par_flip = 1'b0; prog_shft = 1'b0;
        tick();
        check("par_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        check("par_cfg_err", {31'd0, cfg_err}, 32'd1);
        load_uniform(9, 32'h0);
        check("par_clr_err", {31'd0, cfg_err}, 32'd0);
        check("par_clr_ok", {31'd0, cfg_ok}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
